// File: rtl/dn_timer_pkg.sv
// Shared types and default widths for the down-counting timer controller.
package dn_timer_pkg;

  localparam int unsigned DEF_N     = 8;
  localparam int unsigned DEF_PRE_W = 4;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  // Command bundle from the controller to the counter datapath
  typedef struct packed {
    logic load;
    logic en;
  } cnt_cmd_t;

endpackage

// File: rtl/dn_counter_core.sv
// Loadable N-bit binary down counter; load has priority over enable.
module dn_counter_core
  import dn_timer_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  output logic [N-1:0] count_out,
  output logic         zero
);

  logic [N-1:0] count_q, count_d;

  // Next count: reload, decrement or hold
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q - N'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;
  assign zero      = (count_q == '0);

endmodule

// File: rtl/dn_timer_ctrl.sv
// Timer controller: turns start/stop/pause/auto-reload controls into counter
// load/enable commands and produces the done pulse and sticky irq.
// Build option: define DN_TIMER_PRESCALE_EN to add a tick prescaler that
// divides RUN-state ticks by prescale+1.
module dn_timer_ctrl
  import dn_timer_pkg::*;
#(
  parameter int unsigned N     = DEF_N,
  parameter int unsigned PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-1:0]     load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [PRE_W-1:0] prescale,
  input  logic             irq_ack,
  output logic [N-1:0]     count_out,
  output logic             busy,
  output logic             done,
  output logic             irq
);

  state_e   state_q, state_d;
  logic     busy_q, busy_d;
  logic     done_q, done_d;
  logic     irq_q, irq_d;
  cnt_cmd_t cmd_c;
  logic     zero_c;
  logic     run_adv_c;
  logic     pre_clr_c;
  logic     tick_c;

  // RUN cycle with no command pending: the only cycles that may advance time
  assign run_adv_c = (state_q == ST_RUN) & ~stop & ~start & ~pause;
  assign pre_clr_c = start | stop;

`ifdef DN_TIMER_PRESCALE_EN
  logic [PRE_W-1:0] pre_q, pre_d;

  // Prescaler: one tick every prescale+1 advancing clocks, frozen otherwise
  always_comb begin
    tick_c = run_adv_c & (pre_q >= prescale);
    pre_d  = pre_q;
    if (pre_clr_c) begin
      pre_d = '0;
    end else if (run_adv_c) begin
      pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  logic unused_prescale_c;
  assign unused_prescale_c = ^prescale;
  assign tick_c            = run_adv_c;
`endif

  // Next state, counter commands and expiry flags; stop > start > pause
  always_comb begin
    state_d = state_q;
    cmd_c   = '0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!stop && start) begin
          cmd_c.load = 1'b1;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          cmd_c.load = 1'b1;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (tick_c) begin
          if (zero_c) begin
            done_d = 1'b1;
            if (auto_reload) begin
              cmd_c.load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cmd_c.en = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          cmd_c.load = 1'b1;
          state_d    = ST_RUN;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    irq_d  = done_d | (irq_q & ~irq_ack);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
    end
  end

  dn_counter_core #(
    .N(N)
  ) u_core (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cmd_c.load),
    .load_val (load_val),
    .en       (cmd_c.en),
    .count_out(count_out),
    .zero     (zero_c)
  );

  assign busy = busy_q;
  assign done = done_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_dn_timer_ctrl.sv
// Self-checking bench for dn_timer_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_dn_timer_ctrl;

  localparam int unsigned N     = 8;
  localparam int unsigned PRE_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     load_val;
  logic             start, stop, pause, auto_reload, irq_ack;
  logic [PRE_W-1:0] prescale;
  logic [N-1:0]     count_out;
  logic             busy, done, irq;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: timer active/paused, remaining count, clocks toward next tick
  bit m_active, m_paused, m_done, m_irq;
  int m_cnt, m_pre;

  typedef struct {
    logic         st, sp, pa, ar;
    logic [N-1:0] lv;
    logic         ack;
    logic [N-1:0] cnt;
    logic         busy, done, irq;
  } vec_t;

  vec_t vecs[$];

  dn_timer_ctrl #(.N(N), .PRE_W(PRE_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_val   (load_val),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .auto_reload(auto_reload),
    .prescale   (prescale),
    .irq_ack    (irq_ack),
    .count_out  (count_out),
    .busy       (busy),
    .done       (done),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, sp, pa, ar, input int lv, input logic ack,
                              input int cnt, input logic b, d, i);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.ar = ar; v.lv = N'(lv); v.ack = ack;
    v.cnt = N'(cnt); v.busy = b; v.done = d; v.irq = i;
    return v;
  endfunction

  function automatic void model_reset();
    m_active = 0; m_paused = 0; m_done = 0; m_irq = 0; m_cnt = 0; m_pre = 0;
  endfunction

  // One clock of the timer rules, evaluated on the inputs present at the edge
  function automatic void model_step();
    bit expired = 0;
    bit tick;
    if (stop) begin
      m_active = 0; m_paused = 0; m_pre = 0;
    end else if (start) begin
      m_active = 1; m_paused = 0; m_cnt = int'(load_val); m_pre = 0;
    end else if (m_active && m_paused) begin
      if (!pause) m_paused = 0;
    end else if (m_active && pause) begin
      m_paused = 1;
    end else if (m_active) begin
`ifdef DN_TIMER_PRESCALE_EN
      tick  = (m_pre >= int'(prescale));
      m_pre = tick ? 0 : m_pre + 1;
`else
      tick = 1;
`endif
      if (tick) begin
        if (m_cnt == 0) begin
          expired = 1;
          if (auto_reload) m_cnt = int'(load_val);
          else m_active = 0;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
    m_done = expired;
    m_irq  = expired || (m_irq && !irq_ack);
  endfunction

  task automatic chk(input string name, input logic [N-1:0] c, input logic b, d, i);
    n_checks++;
    if (count_out !== c || busy !== b || done !== d || irq !== i) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d busy=%0b done=%0b irq=%0b, want cnt=%0d busy=%0b done=%0b irq=%0b",
               name, count_out, busy, done, irq, c, b, d, i);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, step model at the rising edge
  task automatic cyc(input logic st, sp, pa, ar, input logic [N-1:0] lv, input logic ack,
                     input logic [PRE_W-1:0] ps);
    @(negedge clk);
    start = st; stop = sp; pause = pa; auto_reload = ar;
    load_val = lv; irq_ack = ack; prescale = ps;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    start = 0; stop = 0; pause = 0; auto_reload = 0; irq_ack = 0;
    load_val = '0; prescale = '0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    start = 0; stop = 0; pause = 0; auto_reload = 0; irq_ack = 0;
    load_val = '0; prescale = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("reset_values", '0, 0, 0, 0);

    // One-shot load 3
    vecs.push_back(mk(1,0,0,0,3,0, 3,1,0,0));
    vecs.push_back(mk(0,0,0,0,3,0, 2,1,0,0));
    vecs.push_back(mk(0,0,0,0,3,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0,3,0, 0,1,0,0));
    vecs.push_back(mk(0,0,0,0,3,0, 0,0,1,1));
    vecs.push_back(mk(0,0,0,0,3,0, 0,0,0,1));
    vecs.push_back(mk(0,0,0,0,3,1, 0,0,0,0));
    // Auto-reload load 2, expiry with simultaneous ack
    vecs.push_back(mk(1,0,0,1,2,0, 2,1,0,0));
    vecs.push_back(mk(0,0,0,1,2,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,1,2,0, 0,1,0,0));
    vecs.push_back(mk(0,0,0,1,2,0, 2,1,1,1));
    vecs.push_back(mk(0,0,0,1,2,0, 1,1,0,1));
    vecs.push_back(mk(0,0,0,1,2,0, 0,1,0,1));
    vecs.push_back(mk(0,0,0,1,2,1, 2,1,1,1));
    vecs.push_back(mk(0,0,0,1,2,1, 1,1,0,0));
    vecs.push_back(mk(0,1,0,1,2,0, 1,0,0,0));
    // Stop beats start at 6, then load 0 expires on first tick
    vecs.push_back(mk(1,0,0,0,8,0, 8,1,0,0));
    vecs.push_back(mk(0,0,0,0,8,0, 7,1,0,0));
    vecs.push_back(mk(0,0,0,0,8,0, 6,1,0,0));
    vecs.push_back(mk(1,1,0,0,9,0, 6,0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0, 0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,1));
    vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0));
    // Pause four cycles at 5
    vecs.push_back(mk(1,0,0,0,6,0, 6,1,0,0));
    vecs.push_back(mk(0,0,0,0,6,0, 5,1,0,0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0,0,1,0,6,0, 5,1,0,0));
    vecs.push_back(mk(0,0,0,0,6,0, 5,1,0,0));
    vecs.push_back(mk(0,0,0,0,6,0, 4,1,0,0));
    vecs.push_back(mk(0,1,0,0,6,0, 4,0,0,0));

    foreach (vecs[i]) begin
      cyc(vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].ar, vecs[i].lv, vecs[i].ack, '0);
      chk($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].busy, vecs[i].done, vecs[i].irq);
    end

    // Asynchronous reset in the middle of a count
    cyc(1,0,0,0,8'd5,0,'0);
    cyc(0,0,0,0,8'd5,0,'0);
    cyc(0,0,0,0,8'd5,0,'0);
    chk("pre_reset_count", 8'd3, 1, 0, 0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_midcount", '0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

`ifdef DN_TIMER_PRESCALE_EN
    // Prescale 3, load 1: decrement every 4 clocks, done 8 clocks after start
    cyc(1,0,0,0,8'd1,0,4'd3);
    chk("pre_start", 8'd1, 1, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      cyc(0,0,0,0,8'd1,0,4'd3);
      chk($sformatf("pre_clk%0d", k), (k < 4) ? 8'd1 : 8'd0, 1, 0, 0);
    end
    cyc(0,0,0,0,8'd1,1,4'd3);
    chk("pre_expiry_ack", 8'd0, 0, 1, 1);
    cyc(0,0,0,0,8'd1,0,4'd3);
    chk("pre_after", 8'd0, 0, 0, 1);
`endif

    // Randomized traffic against the model
    do_reset();
    begin
      logic [PRE_W-1:0] ps;
      logic pa, ar;
      ps = PRE_W'($urandom_range(0, 3));
      pa = 0;
      ar = 1;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 7) == 0) pa = ~pa;
        if ($urandom_range(0, 15) == 0) ar = ~ar;
        cyc(($urandom_range(0, 14) == 0), ($urandom_range(0, 29) == 0), pa, ar,
            N'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0), ps);
        chk($sformatf("rand%0d", c), N'(m_cnt), m_active, m_done, m_irq);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
